// File: rtl/cache_mem_arbiter.sv
// Arbiter for the single physical-memory port shared by the I-cache and
// D-cache miss paths. The winning request is registered on the grant edge
// and drives pmem_* unchanged until the memory completes.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | no transaction; evaluates current-cycle requests
// ST_GRANT_I | I-cache line read in flight on pmem
// ST_GRANT_D | D-cache line read or write-back in flight on pmem
module cache_mem_arbiter #(
  parameter int LINE_W       = 256,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [31:0]       i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [31:0]       d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [31:0]       pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic [1:0]        arb_state
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GRANT_I = 2'd1;
  localparam logic [1:0] ST_GRANT_D = 2'd2;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  logic [1:0]        state_q, state_d;
  logic [3:0]        starve_cnt_q, starve_cnt_d;
  logic              cmd_write_q, cmd_write_d;
  logic [31:0]       addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;

  logic d_req;
  logic i_forced;
  logic granted;

  assign d_req    = d_read | d_write;
  // I wins a contested IDLE cycle only once D has used up its streak
  assign i_forced = i_read & (starve_cnt_q == STARVE_MAX);

  // Next-state, grant capture and starvation bookkeeping
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    cmd_write_d  = cmd_write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (d_req && !i_forced) begin
          state_d     = ST_GRANT_D;
          // read+write together is a write-back
          cmd_write_d = d_write;
          addr_d      = d_address;
          wdata_d     = d_wdata;
          if (i_read) begin
            starve_cnt_d = (starve_cnt_q >= STARVE_MAX) ? STARVE_MAX
                                                        : starve_cnt_q + 4'd1;
          end else begin
            starve_cnt_d = 4'd0;
          end
        end else if (i_read) begin
          state_d      = ST_GRANT_I;
          cmd_write_d  = 1'b0;
          addr_d       = i_address;
          wdata_d      = d_wdata;
          starve_cnt_d = 4'd0;
        end
      end
      ST_GRANT_I, ST_GRANT_D: begin
        // requests are not re-examined until the grant completes
        if (pmem_resp) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and captured command registers; reset aborts any transaction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      starve_cnt_q <= 4'd0;
      cmd_write_q  <= 1'b0;
      addr_q       <= 32'd0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      cmd_write_q  <= cmd_write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  // Memory commands decode registered state only, so they cannot glitch
  assign granted      = (state_q != ST_IDLE);
  assign pmem_read    = granted & ~cmd_write_q;
  assign pmem_write   = granted & cmd_write_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;

  // Completion reaches only the current owner, with no added latency
  assign i_resp    = (state_q == ST_GRANT_I) & pmem_resp;
  assign d_resp    = (state_q == ST_GRANT_D) & pmem_resp;
  assign i_rdata   = pmem_rdata;
  assign d_rdata   = pmem_rdata;
  assign arb_state = state_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Randomized bench for cache_mem_arbiter: requester agents and a memory
// model drive the DUT, a transaction-level reference decides grant order,
// and a monitor checks pmem commands and responses against it.
module tb_cache_mem_arbiter;
  localparam int LW = 256;
  localparam int SL = 2;

  typedef struct {
    bit              side_d;
    bit              wr;
    logic [31:0]     addr;
    logic [LW-1:0]   wdata;
  } txn_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_read = 1'b0;
  logic [31:0]   i_address = '0;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read = 1'b0;
  logic          d_write = 1'b0;
  logic [31:0]   d_address = '0;
  logic [LW-1:0] d_wdata = '0;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [31:0]   pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata = '0;
  logic          pmem_resp = 1'b0;
  logic [1:0]    arb_state;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit   m_busy = 0;
  int   m_cnt = 0;
  bit   m_cur_side_d = 0;
  bit   m_cur_wr = 0;
  txn_t exp_q[$];
  int   n_grant = 0;
  int   n_resp = 0;
  int   n_forced = 0;

  // monitor state
  txn_t cur;
  bit   prev_cmd = 0;

  // stimulus state
  bit gen_en = 1;
  bit wr_en = 1;
  bit i_seen = 0;
  bit d_seen = 0;
  bit mem_pending = 0;
  int mem_lat = 0;
  int mem_min_lat = 0;

  cache_mem_arbiter #(.LINE_W(LW), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .arb_state(arb_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom();
    a[4:0] = 5'd0;
    return a;
  endfunction

  // Reference: in an idle cycle D wins unless I has waited SL D grants
  always @(posedge clk) begin : model_p
    txn_t t;
    bit   dreq;
    if (!rst_n) begin
      m_busy = 0;
      m_cnt = 0;
      exp_q.delete();
    end else if (m_busy) begin
      if (pmem_resp) m_busy = 0;
    end else begin
      dreq = d_read | d_write;
      if (dreq && !(i_read && m_cnt == SL)) begin
        t.side_d = 1; t.wr = d_write; t.addr = d_address; t.wdata = d_wdata;
        m_cnt = i_read ? ((m_cnt + 1 > SL) ? SL : m_cnt + 1) : 0;
      end else if (i_read) begin
        if (dreq) n_forced++;
        t.side_d = 0; t.wr = 0; t.addr = i_address; t.wdata = '0;
        m_cnt = 0;
      end
      if (dreq || i_read) begin
        exp_q.push_back(t);
        m_busy = 1;
        m_cur_side_d = t.side_d;
        m_cur_wr = t.wr;
        n_grant++;
      end
    end
  end

  // Monitor: pop on command start, then check command, state and responses
  always @(negedge clk) begin : mon_p
    bit cmd;
    if (!rst_n) begin
      prev_cmd = 0;
    end else begin
      cmd = pmem_read | pmem_write;
      chk("cmd_active", cmd, m_busy);
      if (cmd && !prev_cmd) begin
        if (exp_q.size() == 0) chk("unexpected_cmd", 1, 0);
        else cur = exp_q.pop_front();
      end
      if (cmd) begin
        chk("pmem_write", pmem_write, cur.wr);
        chk("pmem_read", pmem_read, !cur.wr);
        chk("pmem_address", pmem_address, cur.addr);
        if (cur.wr) chk("pmem_wdata", pmem_wdata, cur.wdata);
        chk("arb_state_busy", arb_state, cur.side_d ? 2 : 1);
      end else begin
        chk("arb_state_idle", arb_state, 0);
      end
      chk("i_resp", i_resp, m_busy && !cur.side_d && pmem_resp);
      chk("d_resp", d_resp, m_busy && cur.side_d && pmem_resp);
      chk("i_rdata", i_rdata, pmem_rdata);
      chk("d_rdata", d_rdata, pmem_rdata);
      if (i_resp || d_resp) n_resp++;
      prev_cmd = cmd;
    end
  end

  task automatic drive_mem();
    pmem_rdata = rand_line();
    if (!rst_n) begin
      pmem_resp = 0;
      mem_pending = 0;
    end else if (pmem_resp) begin
      pmem_resp = 0;
    end else if (pmem_read || pmem_write) begin
      if (!mem_pending) begin
        mem_pending = 1;
        mem_lat = mem_min_lat + $urandom_range(3);
      end
      if (mem_lat == 0) begin
        pmem_resp = 1;
        mem_pending = 0;
      end else begin
        mem_lat--;
      end
    end else if ($urandom_range(9) == 0) begin
      pmem_resp = 1;  // spurious completion while idle
    end
  endtask

  task automatic new_d();
    int m;
    m = $urandom_range(3);
    d_write = wr_en && (m >= 2);
    d_read = (m != 2) || !wr_en;
    d_address = rand_addr();
    d_wdata = rand_line();
  endtask

  task automatic drive_agents();
    if (i_read && i_seen) begin
      if (gen_en && $urandom_range(2) == 0) i_address = rand_addr();
      else i_read = 0;
    end else if (!i_read && gen_en && $urandom_range(3) == 0) begin
      i_read = 1;
      i_address = rand_addr();
    end
    if ((d_read || d_write) && d_seen) begin
      if (gen_en && $urandom_range(2) != 0) new_d();
      else begin
        d_read = 0;
        d_write = 0;
      end
    end else if (!(d_read || d_write) && gen_en && $urandom_range(2) == 0) begin
      new_d();
    end else if ((d_read || d_write) && $urandom_range(1) == 1) begin
      d_wdata = rand_line();  // requester changes data mid-wait/transaction
    end
  endtask

  task automatic step();
    @(negedge clk);
    i_seen = i_resp;
    d_seen = d_resp;
    @(posedge clk);
    #1;
    drive_mem();
    drive_agents();
  endtask

  initial begin : stim_p
    bit found;
    bit done;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pmem_read", pmem_read, 0);
    chk("rst_pmem_write", pmem_write, 0);
    chk("rst_pmem_address", pmem_address, 0);
    chk("rst_pmem_wdata", pmem_wdata, 0);
    chk("rst_i_resp", i_resp, 0);
    chk("rst_d_resp", d_resp, 0);
    chk("rst_arb_state", arb_state, 0);
    rst_n = 1;

    for (int n = 0; n < 3000; n++) step();

    // abort a D read two cycles into its grant
    mem_min_lat = 5;
    wr_en = 0;
    found = 0;
    for (int n = 0; n < 400 && !found; n++) begin
      step();
      if (m_busy && m_cur_side_d && !m_cur_wr) found = 1;
    end
    if (!found) chk("reset_hunt_timeout", 1, 0);
    step();
    #2;
    rst_n = 0;
    #1;
    chk("abort_pmem_read", pmem_read, 0);
    chk("abort_pmem_write", pmem_write, 0);
    chk("abort_arb_state", arb_state, 0);
    chk("abort_d_resp", d_resp, 0);
    chk("abort_pmem_address", pmem_address, 0);
    i_read = 0; d_read = 0; d_write = 0;
    pmem_resp = 0; mem_pending = 0;
    repeat (2) @(posedge clk);
    #1;
    n_grant = 0;
    n_resp = 0;
    mem_min_lat = 0;
    wr_en = 1;
    rst_n = 1;
    i_read = 1;
    i_address = 32'h0000_1000;

    for (int n = 0; n < 3000; n++) step();

    gen_en = 0;
    done = 0;
    for (int n = 0; n < 300 && !done; n++) begin
      step();
      if (!i_read && !d_read && !d_write && !m_busy) done = 1;
    end
    if (!done) chk("drain_timeout", 1, 0);
    repeat (3) step();
    chk("exp_queue_empty", exp_q.size(), 0);
    chk("resp_count", n_resp, n_grant);
    chk("starve_forced_seen", n_forced > 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
